wb_pc_stage: RTL and testbench
==============================

# wb_pc_stage

Write-back and PC-update stage of the SEQ Y86-64 processor, directly downstream of the memory stage. Each rising clock edge it commits `valE`/`valM` into the 15-entry register file, loads the next PC, and updates the sticky processor status. It also provides the combinational register read ports used by decode.

## Interface

**Parameters**
- `RESET_PC`, default 64'h0 — PC value loaded on reset.
- `STACK_BASE`, default 64'h0 — reset value of `%rsp`. All other registers reset to 0.

**Ports**
- `clk`  in  1  — rising-edge clock.
- `rst`  in  1  — asynchronous, active-high reset.
- `icode`  in  4  — current instruction code.
- `Cnd`  in  1  — condition flag from execute; used by cmovXX and jXX.
- `rA`, `rB`  in  4 each  — register specifiers; 4'hF means none.
- `valE`, `valM`, `valC`, `valP`  in  64 each  — ALU result, memory data, constant, fall-through PC.
- `instr_valid`  in  1  — fetch decoded a legal icode.
- `imem_error`, `dmem_error`  in  1 each  — instruction-memory / data-memory address errors.
- `srcA`, `srcB`  in  4 each  — decode read addresses.
- `rvalA`, `rvalB`  out  64 each  — combinational read data; 0 when the address is 4'hF.
- `pc`  out  64  — current PC register.
- `stat`  out  3  — status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- `retired`  out  64  — count of committed instructions.

## Operation

**Destination select**
- `dstE` = `rB` for icode 2 with `Cnd`=1, icode 3 and icode 6.
- `dstE` = 4 (`%rsp`) for icodes 8, 9, A, B.
- `dstE` = F otherwise, including cmov with `Cnd`=0.
- `dstM` = `rA` for icodes 5 and B; F otherwise.

**Next PC**
- call (8) → `valC`.
- jXX (7) with `Cnd`=1 → `valC`.
- ret (9) → `valM`.
- All other cases → `valP`.

**Instruction status**, by priority:
1. `imem_error` or `dmem_error` → ADR.
2. otherwise `!instr_valid` → INS.
3. otherwise icode 0 → HLT.
4. otherwise AOK.

**Status FSM**
- States: AOK, HLT, ADR, INS.
- From AOK: move to the instruction status computed above.
- HLT, ADR and INS are absorbing; only `rst` leaves them.

**Commit** happens only when `stat`=AOK and the instruction status is AOK:
- write `valE` to `dstE` and `valM` to `dstM`;
- load the next PC into `pc`;
- increment `retired`.
- If both destinations are equal (popq %rsp), the `valM` write wins.
- Writes to address F are dropped.

**No commit** occurs when the instruction status is non-AOK, or when `stat` is already non-AOK:
- no register writes, `pc` holds, `retired` holds;
- the stage transitions to, or remains in, the faulting state.
- In particular, a halt does not advance `pc`.

## Timing
- Read ports are purely combinational from register state. A write becomes visible on `rvalA`/`rvalB` the cycle after the commit edge; there is no same-cycle bypass.
- Register writes, `pc`, `stat` and `retired` all update on the same rising edge. Commit latency is 1 cycle.
- While `rst`=1 (asynchronous, regardless of `clk`):
  - `pc` = `RESET_PC`;
  - `stat` = AOK;
  - `retired` = 0;
  - `%rsp` = `STACK_BASE`, all other registers = 0.
- Deassertion of `rst` mid-program takes effect immediately. The first edge after deassertion commits the instruction presented on the inputs.
- `retired` wraps from 2^64−1 to 0.

## Configuration
- `WB_RETIRE_CNT_EN` defined: the `retired` counter is implemented as described above.
- `WB_RETIRE_CNT_EN` undefined: the counter flops are omitted and `retired` is tied to 0. All other behaviour is identical.

## Structure
- Package `y86_pkg` holds:
  - icode constants: `I_HALT`..`I_POPQ`;
  - status codes: `S_AOK`, `S_HLT`, `S_ADR`, `S_INS`;
  - `R_NONE`=4'hF and `R_RSP`=4'h4.
- Sub-module `y86_regfile`: 15×64 storage with two combinational read ports and two write ports. Port M has priority on an address collision. Asynchronous reset with `STACK_BASE` for `%rsp`.
- `wb_pc_stage` contains the destination select, next-PC mux, status FSM and retire counter.

## Test plan
- **Reset:** assert `rst` with `RESET_PC`=64'h100 and `STACK_BASE`=64'h200 → `pc`=64'h100, `stat`=1, `rvalA` with `srcA`=4 returns 64'h200, `retired`=0.
- **irmovq:** icode 3, `rB`=2, `valE`=100, `valP`=10 → after one edge, reg2=100, `pc`=10, `retired`=1. Then issue cmov (icode 2, `rB`=3, `Cnd`=0, `valE`=7) → reg3 unchanged, `pc`=`valP`.
- **popq %rsp:** icode B, `rA`=4, `valE`=208, `valM`=55 → `%rsp`=55. Then issue call (icode 8, `valE`=200, `valC`=64'h40) → `%rsp`=200, `pc`=64'h40.
- **ret and jumps:**
  - icode 9, `valM`=87 → `pc`=87.
  - jXX, `Cnd`=0, `valP`=20 → `pc`=20.
  - jXX, `Cnd`=1, `valC`=64'h80 → `pc`=64'h80.
- **Faults:**
  - `dmem_error`=1 on mrmovq → `stat`=3, no register write, `pc` holds.
  - A following valid irmovq is still blocked; `stat` stays 3 until `rst`.
  - `instr_valid`=0 from AOK → `stat`=4.
- **halt:** icode 0 at `pc`=64'h30 → `stat`=2, `pc` stays 64'h30, `retired` stops.
  - With `WB_RETIRE_CNT_EN` undefined, `retired` reads 0 throughout.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, status codes and register specifiers.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] R_NONE = 4'hF;
    localparam logic [3:0] R_RSP  = 4'h4;

    typedef enum logic [2:0] {
        StAok = S_AOK,
        StHlt = S_HLT,
        StAdr = S_ADR,
        StIns = S_INS
    } stat_e;

endpackage

// File: rtl/y86_regfile.sv
// 15x64 Y86-64 register file: two combinational read ports, two write ports (M wins on collision).
module y86_regfile
    import y86_pkg::*;
#(
    parameter logic [63:0] STACK_BASE = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src_a_i,
    input  logic [3:0]  src_b_i,
    output logic [63:0] rval_a_o,
    output logic [63:0] rval_b_o,
    input  logic [3:0]  dst_e_i,
    input  logic [63:0] val_e_i,
    input  logic [3:0]  dst_m_i,
    input  logic [63:0] val_m_i
);

    logic [63:0] regs_q [15];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= (4'(i) == R_RSP) ? STACK_BASE : 64'h0;
            end
        end else begin
            // R_NONE never matches an index below 15, so those writes drop out.
            for (int i = 0; i < 15; i++) begin
                if (dst_m_i == 4'(i)) begin
                    regs_q[i] <= val_m_i;
                end else if (dst_e_i == 4'(i)) begin
                    regs_q[i] <= val_e_i;
                end
            end
        end
    end

    assign rval_a_o = (src_a_i == R_NONE) ? 64'h0 : regs_q[src_a_i];
    assign rval_b_o = (src_b_i == R_NONE) ? 64'h0 : regs_q[src_b_i];

endmodule

// File: rtl/wb_pc_stage.sv
// SEQ Y86-64 write-back / PC-update stage: register commit, next PC, sticky status, retire count.
// Define WB_RETIRE_CNT_EN to implement the retired-instruction counter; otherwise retired is 0.
module wb_pc_stage
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [63:0] STACK_BASE = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode,
    input  logic        Cnd,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        dmem_error,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] rvalA,
    output logic [63:0] rvalB,
    output logic [63:0] pc,
    output logic [2:0]  stat,
    output logic [63:0] retired
);

    stat_e       state_q, state_d;
    stat_e       inst_stat;
    logic        commit;
    logic [3:0]  dst_e, dst_m;
    logic [63:0] pc_q, pc_d;

    always_comb begin
        dst_e = R_NONE;
        dst_m = R_NONE;
        unique case (icode)
            I_RRMOVQ:                        dst_e = Cnd ? rB : R_NONE;
            I_IRMOVQ, I_OPQ:                 dst_e = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:  dst_e = R_RSP;
            default:                         dst_e = R_NONE;
        endcase
        if (icode == I_MRMOVQ || icode == I_POPQ) begin
            dst_m = rA;
        end
    end

    always_comb begin
        if (imem_error || dmem_error) begin
            inst_stat = StAdr;
        end else if (!instr_valid) begin
            inst_stat = StIns;
        end else if (icode == I_HALT) begin
            inst_stat = StHlt;
        end else begin
            inst_stat = StAok;
        end
    end

    assign commit = (state_q == StAok) && (inst_stat == StAok);

    always_comb begin
        state_d = state_q;
        if (state_q == StAok) begin
            state_d = inst_stat;
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (commit) begin
            if (icode == I_CALL || (icode == I_JXX && Cnd)) begin
                pc_d = valC;
            end else if (icode == I_RET) begin
                pc_d = valM;
            end else begin
                pc_d = valP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StAok;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retired_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= 64'h0;
        end else if (commit) begin
            retired_q <= retired_q + 64'h1;
        end
    end

    assign retired = retired_q;
`else
    assign retired = 64'h0;
`endif

    y86_regfile #(
        .STACK_BASE(STACK_BASE)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .src_a_i  (srcA),
        .src_b_i  (srcB),
        .rval_a_o (rvalA),
        .rval_b_o (rvalB),
        .dst_e_i  (commit ? dst_e : R_NONE),
        .val_e_i  (valE),
        .dst_m_i  (commit ? dst_m : R_NONE),
        .val_m_i  (valM)
    );

    assign pc   = pc_q;
    assign stat = state_q;

endmodule

// File: tb/tb_wb_pc_stage.sv
// Self-checking bench for wb_pc_stage: directed test-plan cases, then random instructions
// against a behavioural model of the SEQ write-back rules.
module tb_wb_pc_stage;

    localparam logic [63:0] RPC = 64'h100;
    localparam logic [63:0] SB  = 64'h200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  icode = '0, rA = 4'hF, rB = 4'hF, srcA = 4'hF, srcB = 4'hF;
    logic        Cnd = 1'b0, instr_valid = 1'b1, imem_error = 1'b0, dmem_error = 1'b0;
    logic [63:0] valE = '0, valM = '0, valC = '0, valP = '0;
    logic [63:0] rvalA, rvalB, pc, retired;
    logic [2:0]  stat;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [63:0] m_reg [15];
    logic [63:0] m_pc, m_ret;
    int          m_stat;

    always #5 clk = ~clk;

    wb_pc_stage #(
        .RESET_PC   (RPC),
        .STACK_BASE (SB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .icode       (icode),
        .Cnd         (Cnd),
        .rA          (rA),
        .rB          (rB),
        .valE        (valE),
        .valM        (valM),
        .valC        (valC),
        .valP        (valP),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .dmem_error  (dmem_error),
        .srcA        (srcA),
        .srcB        (srcB),
        .rvalA       (rvalA),
        .rvalB       (rvalB),
        .pc          (pc),
        .stat        (stat),
        .retired     (retired)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_read(input logic [3:0] a);
        return (a == 4'hF) ? 64'h0 : m_reg[a];
    endfunction

    function automatic logic [63:0] exp_retired();
`ifdef WB_RETIRE_CNT_EN
        return m_ret;
`else
        return 64'h0;
`endif
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_pc"}, pc, m_pc);
        check({tag, "_stat"}, {61'h0, stat}, 64'(m_stat));
        check({tag, "_ret"}, retired, exp_retired());
    endtask

    // Called at a negative edge; leaves control at the next negative edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 15; i++) m_reg[i] = (i == 4) ? SB : 64'h0;
        m_pc = RPC;
        m_ret = 0;
        m_stat = 1;
        srcA = 4'h4;
        srcB = 4'h0;
        #1;
        check("rst_rsp", rvalA, SB);
        check("rst_r0", rvalB, 64'h0);
        check_state("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Apply model rules for one clock edge given the current inputs.
    task automatic model_edge();
        int ist;
        logic [3:0] de, dm;
        if (imem_error || dmem_error) ist = 3;
        else if (!instr_valid)        ist = 4;
        else if (icode == 4'h0)       ist = 2;
        else                          ist = 1;
        if (m_stat == 1 && ist == 1) begin
            de = 4'hF;
            dm = 4'hF;
            if ((icode == 4'h2 && Cnd) || icode == 4'h3 || icode == 4'h6) de = rB;
            if (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) de = 4'h4;
            if (icode == 4'h5 || icode == 4'hB) dm = rA;
            if (de != 4'hF) m_reg[de] = valE;
            if (dm != 4'hF) m_reg[dm] = valM;
            if (icode == 4'h8 || (icode == 4'h7 && Cnd)) m_pc = valC;
            else if (icode == 4'h9) m_pc = valM;
            else m_pc = valP;
            m_ret = m_ret + 1;
        end else if (m_stat == 1) begin
            m_stat = ist;
        end
    endtask

    // Called at a negative edge; leaves control at the next negative edge.
    task automatic step(input logic [3:0] ic, input logic c, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm,
                        input logic [63:0] vc, input logic [63:0] vp, input logic iv,
                        input logic ie, input logic dme, input string tag);
        icode = ic; Cnd = c; rA = ra; rB = rb;
        valE = ve; valM = vm; valC = vc; valP = vp;
        instr_valid = iv; imem_error = ie; dmem_error = dme;
        srcA = 4'($urandom_range(0, 15));
        srcB = 4'($urandom_range(0, 15));
        #1;
        check({tag, "_rvalA"}, rvalA, m_read(srcA));
        check({tag, "_rvalB"}, rvalB, m_read(srcB));
        @(posedge clk);
        model_edge();
        #1;
        check_state(tag);
        @(negedge clk);
    endtask

    task automatic peek(input string tag, input logic [3:0] a, input logic [63:0] exp);
        srcA = a;
        #1;
        check(tag, rvalA, exp);
    endtask

    function automatic logic [63:0] rnd64();
        return ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
    endfunction

    initial begin
        @(negedge clk);
        do_reset();

        // irmovq then cmov-not-taken
        step(4'h3, 1'b0, 4'hF, 4'h2, 64'd100, 0, 0, 64'd10, 1, 0, 0, "irmovq");
        peek("irmovq_r2", 4'h2, 64'd100);
        check("irmovq_pc", pc, 64'd10);
        step(4'h2, 1'b0, 4'h1, 4'h3, 64'd7, 0, 0, 64'd12, 1, 0, 0, "cmov_nt");
        peek("cmov_r3", 4'h3, 64'd0);
        check("cmov_pc", pc, 64'd12);

        // popq %rsp then call
        step(4'hB, 1'b0, 4'h4, 4'hF, 64'd208, 64'd55, 0, 64'd14, 1, 0, 0, "popq_rsp");
        peek("popq_rsp_val", 4'h4, 64'd55);
        step(4'h8, 1'b0, 4'hF, 4'hF, 64'd200, 0, 64'h40, 64'd23, 1, 0, 0, "call");
        peek("call_rsp", 4'h4, 64'd200);
        check("call_pc", pc, 64'h40);

        // ret and jumps
        step(4'h9, 1'b0, 4'hF, 4'hF, 64'd208, 64'd87, 0, 64'd1, 1, 0, 0, "ret");
        check("ret_pc", pc, 64'd87);
        step(4'h7, 1'b0, 4'hF, 4'hF, 0, 0, 64'h80, 64'd20, 1, 0, 0, "jxx_nt");
        check("jxx_nt_pc", pc, 64'd20);
        step(4'h7, 1'b1, 4'hF, 4'hF, 0, 0, 64'h80, 64'd29, 1, 0, 0, "jxx_t");
        check("jxx_t_pc", pc, 64'h80);

        // dmem fault is sticky
        step(4'h5, 1'b0, 4'h1, 4'h2, 64'h8, 64'h99, 0, 64'h8a, 1, 0, 1, "dmem_err");
        check("dmem_stat", {61'h0, stat}, 64'd3);
        check("dmem_pc", pc, 64'h80);
        step(4'h3, 1'b0, 4'hF, 4'h5, 64'd9, 0, 0, 64'h94, 1, 0, 0, "after_adr");
        peek("after_adr_r5", 4'h5, 64'd0);
        check("after_adr_stat", {61'h0, stat}, 64'd3);
        do_reset();

        // illegal instruction
        step(4'hC, 1'b0, 4'hF, 4'hF, 0, 0, 0, 64'd1, 0, 0, 0, "ins");
        check("ins_stat", {61'h0, stat}, 64'd4);
        do_reset();

        // halt at 0x30
        step(4'h7, 1'b1, 4'hF, 4'hF, 0, 0, 64'h30, 64'd9, 1, 0, 0, "jmp30");
        step(4'h0, 1'b0, 4'hF, 4'hF, 0, 0, 0, 64'h31, 1, 0, 0, "halt");
        check("halt_stat", {61'h0, stat}, 64'd2);
        check("halt_pc", pc, 64'h30);
        step(4'h1, 1'b0, 4'hF, 4'hF, 0, 0, 0, 64'h32, 1, 0, 0, "post_halt");
        check("post_halt_pc", pc, 64'h30);
        do_reset();

        // Random instruction stream with occasional faults and resets
        for (int n = 0; n < 800; n++) begin
            logic [3:0] ic;
            ic = ($urandom_range(0, 15) == 0) ? 4'h0 : 4'($urandom_range(1, 11));
            step(ic, 1'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 rnd64(), rnd64(), rnd64(), rnd64(),
                 ($urandom_range(0, 31) != 0), ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 63) == 0), "rnd");
            if (m_stat != 1 && $urandom_range(0, 3) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
